// File: rtl/vga_display_engine_if.sv
// Frame / edge BRAM read port shared by the VGA display engine.
// The engine drives the address; both memories return data MEM_LATENCY cycles later.
interface vga_display_engine_if #(
    parameter int ADDR_W = 19,
    parameter int CH_W   = 4,
    parameter int EDGE_W = 3
);
    logic [ADDR_W-1:0] mem_addr;
    logic [3*CH_W-1:0] rgb_data;
    logic [EDGE_W-1:0] edge_data;

    modport master (
        output mem_addr,
        input  rgb_data,
        input  edge_data
    );

    modport slave (
        input  mem_addr,
        output rgb_data,
        output edge_data
    );
endinterface

// File: rtl/vga_display_engine.sv
// VGA timing generator with latency-compensated frame BRAM fetch
// and four frame-latched render modes (RGB, gray, edge, edge over gray).
module vga_display_engine #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int ADDR_W      = 19,
    parameter int CH_W        = 4,
    parameter int EDGE_W      = 3,
    parameter int MEM_LATENCY = 2,
    parameter bit SYNC_POL    = 1'b0
) (
    input  logic                video_clk,
    input  logic                reset_n,
    input  logic [1:0]          mode,
    input  logic [3*CH_W-1:0]   overlay_color,
    vga_display_engine_if.master mem,
    output logic                hsync,
    output logic                vsync,
    output logic                de,
    output logic [3*CH_W-1:0]   video_out,
    output logic                frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = $clog2(H_TOTAL + 1);
    localparam int VW = $clog2(V_TOTAL + 1);

    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

    typedef struct packed {
        logic [1:0] md;
        logic       fs;
        logic       vs;
        logic       hs;
        logic       act;
    } flags_t;

    logic [HW-1:0] hcount;
    logic [VW-1:0] vcount;
    logic [1:0]    mode_q;
    logic          h_end;
    logic          wrap;
    flags_t        st0;
    flags_t        dly [MEM_LATENCY];
    flags_t        tl;

    assign h_end = (hcount == H_LAST);
    assign wrap  = h_end && (vcount == V_LAST);

    always_comb begin
        st0.md  = mode_q;
        st0.act = (hcount < H_ACT) && (vcount < V_ACT);
        st0.hs  = (hcount >= HS_BEG) && (hcount < HS_END);
        st0.vs  = (vcount >= VS_BEG) && (vcount < VS_END);
        st0.fs  = st0.act && (hcount == '0) && (vcount == '0);
    end

    // Address tracks the raster incrementally and freezes through blanking.
    always_ff @(posedge video_clk or negedge reset_n) begin
        if (!reset_n) begin
            hcount       <= '0;
            vcount       <= '0;
            mode_q       <= '0;
            mem.mem_addr <= '0;
        end else begin
            if (h_end) begin
                hcount <= '0;
                vcount <= wrap ? '0 : vcount + VW'(1);
            end else begin
                hcount <= hcount + HW'(1);
            end
            if (wrap) begin
                mem.mem_addr <= '0;
                mode_q       <= mode;
            end else if (st0.act) begin
                mem.mem_addr <= mem.mem_addr + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge video_clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < MEM_LATENCY; i++) dly[i] <= '0;
        end else begin
            dly[0] <= st0;
            for (int i = 1; i < MEM_LATENCY; i++) dly[i] <= dly[i-1];
        end
    end

    assign tl = dly[MEM_LATENCY-1];

    logic [CH_W-1:0]   r_ch, g_ch, b_ch, gray;
    logic [CH_W+1:0]   gsum;
    logic [3*CH_W-1:0] gray_px;
    logic [3*CH_W-1:0] pix;
    logic              is_edge;

    assign {r_ch, g_ch, b_ch} = mem.rgb_data;
    assign is_edge = |mem.edge_data;

    always_comb begin
        gsum = {2'b00, r_ch >> 2} + {2'b00, g_ch >> 1}
             + {2'b00, g_ch >> 3} + {2'b00, b_ch >> 3};
        gray = (|gsum[CH_W+1:CH_W]) ? '1 : gsum[CH_W-1:0];
        gray_px = {gray, gray, gray};
    end

    always_comb begin
        pix = '0;
        case (tl.md)
            2'd0:    pix = mem.rgb_data;
            2'd1:    pix = gray_px;
            2'd2:    pix = is_edge ? overlay_color : '0;
            default: pix = is_edge ? overlay_color : gray_px;
        endcase
    end

    always_ff @(posedge video_clk or negedge reset_n) begin
        if (!reset_n) begin
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            de          <= 1'b0;
            frame_start <= 1'b0;
            video_out   <= '0;
        end else begin
            hsync       <= tl.hs ? SYNC_POL : ~SYNC_POL;
            vsync       <= tl.vs ? SYNC_POL : ~SYNC_POL;
            de          <= tl.act;
            frame_start <= tl.fs;
            video_out   <= tl.act ? pix : '0;
        end
    end
endmodule

// File: tb/tb_vga_display_engine.sv
// Bench for vga_display_engine: three instances (latency 1/2/3) on a small
// raster, checked every cycle against a frame-arithmetic reference model.
module tb_vga_display_engine;
    localparam int HA = 8, HF = 2, HS = 3, HB = 2;
    localparam int VA = 6, VF = 1, VS = 2, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;
    localparam int AW = 8;

    typedef struct {
        logic [11:0] rgb;
        logic [2:0]  edg;
        logic [1:0]  md;
        logic [11:0] ovl;
        logic [11:0] exp;
    } vec_t;

    logic        video_clk = 1'b0;
    logic        reset_n   = 1'b0;
    logic [1:0]  mode      = 2'd0;
    logic [11:0] overlay_color = 12'h000;

    logic [11:0] rgb_mem  [256];
    logic [2:0]  edge_mem [256];

    logic [AW-1:0] addr_w [3];
    logic          hs_w [3], vs_w [3], de_w [3], fs_w [3];
    logic [11:0]   vid_w [3];

    int checks = 0;
    int errors = 0;
    int cnt = 0;
    logic [1:0] fm = 2'd0;

    always #5 video_clk = ~video_clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int LAT = g + 1;
        vga_display_engine_if #(.ADDR_W(AW), .CH_W(4), .EDGE_W(3)) bus ();
        logic [AW-1:0] pipe [LAT];

        always @(posedge video_clk) begin
            pipe[0] <= bus.mem_addr;
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end

        assign bus.rgb_data  = rgb_mem[pipe[LAT-1]];
        assign bus.edge_data = edge_mem[pipe[LAT-1]];
        assign addr_w[g]     = bus.mem_addr;

        vga_display_engine #(
            .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
            .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
            .ADDR_W(AW), .CH_W(4), .EDGE_W(3),
            .MEM_LATENCY(LAT), .SYNC_POL(g == 2)
        ) dut (
            .video_clk     (video_clk),
            .reset_n       (reset_n),
            .mode          (mode),
            .overlay_color (overlay_color),
            .mem           (bus),
            .hsync         (hs_w[g]),
            .vsync         (vs_w[g]),
            .de            (de_w[g]),
            .video_out     (vid_w[g]),
            .frame_start   (fs_w[g])
        );
    end

    task automatic cmp(input string nm, input int id,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d got %0h expected %0h at %0t",
                     nm, id, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] gray12(input logic [11:0] p);
        int gv;
        gv = p[11:8] / 4 + p[7:4] / 2 + p[7:4] / 8 + p[3:0] / 8;
        if (gv > 15) gv = 15;
        return {3{gv[3:0]}};
    endfunction

    function automatic logic [11:0] pix_exp(input logic [1:0] md,
        input logic [11:0] p, input logic [2:0] e, input logic [11:0] ovl);
        case (md)
            2'd0:    return p;
            2'd1:    return gray12(p);
            2'd2:    return (e != 0) ? ovl : 12'h000;
            default: return (e != 0) ? ovl : gray12(p);
        endcase
    endfunction

    // Pins in cycle cnt show raster position cnt-L; mem_addr shows position cnt.
    task automatic check_dut(input int g);
        int s, r, h, v, r0, h0, v0, a;
        logic pol, e_de, e_hs, e_vs, e_fs;
        logic [11:0] e_vid;
        logic [AW-1:0] e_addr;
        pol = (g == 2);
        s = cnt - (g + 2);
        r0 = cnt % FT;
        h0 = r0 % HT;
        v0 = r0 / HT;
        if (v0 < VA) e_addr = AW'(v0 * HA + ((h0 < HA) ? h0 : HA));
        else e_addr = AW'(HA * VA);
        e_de = 1'b0;
        e_hs = ~pol;
        e_vs = ~pol;
        e_fs = 1'b0;
        e_vid = 12'h000;
        if (s >= 0) begin
            r = s % FT;
            h = r % HT;
            v = r / HT;
            e_de = (h < HA) && (v < VA);
            if (h >= HA + HF && h < HA + HF + HS) e_hs = pol;
            if (v >= VA + VF && v < VA + VF + VS) e_vs = pol;
            e_fs = (r == 0);
            if (e_de) begin
                a = v * HA + h;
                e_vid = pix_exp(fm, rgb_mem[a], edge_mem[a], overlay_color);
            end
        end
        cmp("mem_addr", g, 32'(addr_w[g]), 32'(e_addr));
        cmp("de", g, 32'(de_w[g]), 32'(e_de));
        cmp("hsync", g, 32'(hs_w[g]), 32'(e_hs));
        cmp("vsync", g, 32'(vs_w[g]), 32'(e_vs));
        cmp("frame_start", g, 32'(fs_w[g]), 32'(e_fs));
        cmp("video_out", g, 32'(vid_w[g]), 32'(e_vid));
    endtask

    always @(posedge video_clk) begin
        if (!reset_n) begin
            cnt = 0;
            fm = 2'd0;
        end else begin
            if (cnt % FT == FT - 1) fm = mode;
            cnt++;
        end
        #1;
        for (int g = 0; g < 3; g++) check_dut(g);
    end

    task automatic fill_rand();
        for (int i = 0; i < 256; i++) begin
            rgb_mem[i]  = 12'($urandom);
            edge_mem[i] = ($urandom_range(0, 1) == 1) ? 3'($urandom) : 3'd0;
        end
    endtask

    task automatic wait_r(input int r);
        for (int i = 0; i < 2 * FT + 5; i++) begin
            @(posedge video_clk);
            #2;
            if (cnt % FT == r) return;
        end
        cmp("wait_r_timeout", 0, 32'd1, 32'd0);
    endtask

    task automatic wait_fs(output int n);
        n = 0;
        for (int i = 0; i < 2 * FT + 5; i++) begin
            @(posedge video_clk);
            #2;
            n++;
            if (fs_w[1]) return;
        end
        cmp("frame_start_timeout", 1, 32'd1, 32'd0);
    endtask

    vec_t vecs [10];
    int n;

    initial begin
        vecs[0] = '{12'hFFF, 3'd0, 2'd1, 12'hF00, 12'hCCC};
        vecs[1] = '{12'h840, 3'd0, 2'd1, 12'hF00, 12'h444};
        vecs[2] = '{12'h000, 3'd0, 2'd1, 12'hF00, 12'h000};
        vecs[3] = '{12'h123, 3'd1, 2'd2, 12'hF00, 12'hF00};
        vecs[4] = '{12'hFFF, 3'd0, 2'd2, 12'hF00, 12'h000};
        vecs[5] = '{12'hFFF, 3'd0, 2'd3, 12'hF00, 12'hCCC};
        vecs[6] = '{12'h840, 3'd4, 2'd3, 12'hF00, 12'hF00};
        vecs[7] = '{12'hA5C, 3'd0, 2'd0, 12'h0F0, 12'hA5C};
        vecs[8] = '{12'h840, 3'd2, 2'd0, 12'h0F0, 12'h840};
        vecs[9] = '{12'h0F0, 3'd0, 2'd3, 12'h00F, 12'h888};

        fill_rand();
        repeat (10) begin
            @(negedge video_clk);
            mode = 2'($urandom_range(0, 3));
            overlay_color = 12'($urandom);
        end
        @(negedge video_clk);
        reset_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            wait_r(100);
            for (int a = 0; a < 256; a++) begin
                rgb_mem[a]  = vecs[i].rgb;
                edge_mem[a] = vecs[i].edg;
            end
            mode = vecs[i].md;
            overlay_color = vecs[i].ovl;
            wait_fs(n);
            cmp("vec_video", i, 32'(vid_w[1]), 32'(vecs[i].exp));
            cmp("vec_de", i, 32'(de_w[1]), 32'd1);
        end

        // data == address, RGB passthrough
        wait_r(100);
        for (int a = 0; a < 256; a++) begin
            rgb_mem[a]  = 12'(a);
            edge_mem[a] = 3'd0;
        end
        mode = 2'd0;
        wait_fs(n);
        wait_fs(n);
        cmp("fs_period", 1, 32'(n), 32'(FT));

        // mid-frame mode switch takes effect only at the next frame
        wait_r(100);
        fill_rand();
        mode = 2'd0;
        wait_r(3 * HT + 4);
        mode = 2'd1;
        wait_r(4 * HT + 5);
        cmp("latch_old", 1, 32'(vid_w[1]), 32'(rgb_mem[4 * HA + 2]));
        wait_fs(n);
        cmp("latch_new", 1, 32'(vid_w[1]), 32'(gray12(rgb_mem[0])));

        for (int f = 0; f < 12; f++) begin
            wait_r(100);
            fill_rand();
            overlay_color = 12'($urandom);
            mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) begin
                wait_r($urandom_range(20, 80));
                mode = 2'($urandom_range(0, 3));
            end
        end

        // asynchronous reset in the middle of a visible line
        wait_r(3 * HT + 5);
        #1;
        reset_n = 1'b0;
        #1;
        for (int g = 0; g < 3; g++) begin
            cmp("rst_de", g, 32'(de_w[g]), 32'd0);
            cmp("rst_video", g, 32'(vid_w[g]), 32'd0);
            cmp("rst_fs", g, 32'(fs_w[g]), 32'd0);
            cmp("rst_addr", g, 32'(addr_w[g]), 32'd0);
            cmp("rst_hsync", g, 32'(hs_w[g]), 32'(g != 2));
            cmp("rst_vsync", g, 32'(vs_w[g]), 32'(g != 2));
        end
        repeat (3) @(negedge video_clk);
        reset_n = 1'b1;
        wait_fs(n);
        cmp("restart_latency", 1, 32'(n), 32'd3);
        wait_fs(n);
        cmp("restart_period", 1, 32'(n), 32'(FT));

        repeat (5) @(posedge video_clk);
        #3;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/vga_display_engine.md
Name: vga_display_engine

Overview:
- Parametrised successor to the VGA playback block. Generates configurable VGA timing and fetches pixels from frame BRAM using an incremental address counter.
- Compensates for a parametrised memory read latency so that sync and pixel outputs stay aligned.
- Renders one of four frame-latched display modes: RGB passthrough, grayscale, edge-only, and edge overlay on grayscale.
- Sits between the frame buffer / edge BRAM and the VGA pins.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- ADDR_W, 19, memory address width; must satisfy 2^ADDR_W >= H_ACTIVE*V_ACTIVE
- CH_W, 4, bits per colour channel; pixel width is 3*CH_W
- EDGE_W, 3, edge memory word width
- MEM_LATENCY, 2, read latency of both memories in cycles (>=1)
- SYNC_POL, 0, sync polarity: 0 = active-low, 1 = active-high

Ports:
- video_clk  in  1  pixel clock
- reset_n  in  1  asynchronous active-low reset
- mode  in  2  display mode: 0 RGB, 1 gray, 2 edge-only, 3 edge over gray
- overlay_color  in  3*CH_W  colour drawn for edge pixels
- rgb_data  in  3*CH_W  frame buffer read data, {R,G,B}
- edge_data  in  EDGE_W  edge BRAM read data
- mem_addr  out  ADDR_W  read address shared by both memories
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- de  out  1  data enable, high during visible pixels
- video_out  out  3*CH_W  pixel to DAC, {R,G,B}
- frame_start  out  1  one-cycle pulse aligned with pixel (0,0) on the output

Behaviour:
- Reset: reset_n is asynchronous and active-low. While reset is asserted:
  - hcount, vcount, mem_addr, video_out, de, frame_start are all 0;
  - hsync and vsync are at their inactive level (~SYNC_POL);
  - the latched mode is 0;
  - all pipeline stages are cleared.
- Reset mid-frame: the frame is abandoned immediately. After release, counting restarts at (0,0) on the first edge.
- Stage 0 counters:
  - hcount runs 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP.
  - vcount increments when hcount wraps and runs 0..V_TOTAL-1, where V_TOTAL is defined the same way.
- Stage 0 flags:
  - active = (hcount < H_ACTIVE) and (vcount < V_ACTIVE).
  - hs0 is asserted for H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC.
  - vs0 is asserted for V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC, for whole lines.
- mem_addr:
  - It is registered and always equals vcount*H_ACTIVE + hcount whenever active; no multiplier is used.
  - It advances by 1 each active cycle and holds its value through blanking.
  - It returns to 0 at the frame wrap (hcount = H_TOTAL-1 and vcount = V_TOTAL-1).
- Pipeline alignment:
  - active, hs0, vs0 and the frame-start flag (active at (0,0)) are delayed MEM_LATENCY cycles so they line up with the returned rgb_data/edge_data.
  - They then pass through one output register.
  - Total latency from counter state to pins is L = MEM_LATENCY+1 cycles for every output.
- Mode latch:
  - mode is sampled only at the frame wrap cycle and applies to the entire next frame.
  - A mid-frame change of the input has no visible effect until then.
- Grayscale:
  - gray = (R>>2) + (G>>1) + (G>>3) + (B>>3), computed in CH_W+2 bits.
  - The result saturates to 2^CH_W-1 and is replicated as {gray,gray,gray}.
- Edge test: an edge pixel is any pixel with edge_data != 0.
- Output mux, applied when the delayed active flag is high (otherwise video_out = 0):
  - mode 0: rgb_data
  - mode 1: gray
  - mode 2: overlay_color if edge, else 0
  - mode 3: overlay_color if edge, else gray
- Output levels:
  - hsync = hs_delayed XNOR SYNC_POL-equivalent, i.e. it is at the active level while the delayed flag is high.
  - vsync is formed the same way.
  - de is the delayed active flag.
  - frame_start is high for exactly 1 cycle per frame.
- Event coincidence: the frame wrap, line wrap, mode latch and mem_addr reset all occur on the same cycle; none has priority issues because each updates separate state.

Test Plan:
- Reset behaviour: hold reset_n=0 for 10 cycles with random inputs.
  - Required: all outputs at reset values (hsync=vsync=1 for SYNC_POL=0, video_out=0).
  - Then release and assert reset_n low mid-line 100. Required: outputs return to reset values asynchronously and counting restarts at (0,0).
- Timing at defaults:
  - hsync period is 800 cycles, low for 96 cycles, starting 656 cycles after the first de rise of the line.
  - vsync is low for exactly 2 lines every 525 lines.
  - de is high for 640 cycles on each of 480 lines.
- Address sequence:
  - mem_addr steps 0..307199 over the active area, holds during blanking, and returns to 0 at the next frame.
  - With a bench memory model of latency MEM_LATENCY returning data=address, video_out in mode 0 equals address[11:0] on the de-aligned cycle. Repeat with MEM_LATENCY=1 and MEM_LATENCY=3.
- Grayscale (mode 1):
  - rgb_data=12'hFFF gives video_out=12'hCCC.
  - rgb_data=12'h840 gives video_out=12'h444.
  - rgb_data=12'h000 gives video_out=12'h000.
- Edge modes (overlay_color=12'hF00):
  - mode 2: edge_data=3'b001 gives 12'hF00; edge_data=0 gives 12'h000.
  - mode 3: edge_data=0 with rgb_data=12'hFFF gives 12'hCCC.
- Mode latching:
  - Switch mode from 0 to 1 at line 200. Required: the remainder of that frame is RGB and the next frame is gray from pixel (0,0).
  - Required: frame_start pulses once per 420000 cycles, coincident with the first de cycle.
